// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster timing constants and counter types
// shared by vga_timing and vga_frame_reader
package vga_pkg;

    typedef logic [9:0] h_cnt_t;
    typedef logic [9:0] v_cnt_t;

    localparam h_cnt_t H_ACTIVE = 10'd640;
    localparam h_cnt_t H_FP     = 10'd16;
    localparam h_cnt_t H_SYNC   = 10'd96;
    localparam h_cnt_t H_BP     = 10'd48;
    localparam h_cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam v_cnt_t V_ACTIVE = 10'd480;
    localparam v_cnt_t V_FP     = 10'd10;
    localparam v_cnt_t V_SYNC   = 10'd2;
    localparam v_cnt_t V_BP     = 10'd33;
    localparam v_cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam h_cnt_t H_SYNC_START = H_ACTIVE + H_FP;
    localparam h_cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam h_cnt_t H_LAST       = H_TOTAL - 10'd1;

    localparam v_cnt_t V_SYNC_START = V_ACTIVE + V_FP;
    localparam v_cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam v_cnt_t V_LAST       = V_TOTAL - 10'd1;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate enable, raster counters, raw syncs,
// active-area flag and a frame_start pulse on wrap to (0,0)
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       frame_start
);

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // pixel-rate enable toggles every clk (clk/2)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix_en <= 1'b0;
        else       pix_en <= ~pix_en;
    end

    // raster counters advance once per pixel tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // one-clk pulse in the cycle right after the wrap to (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_start <= 1'b0;
        else       frame_start <= pix_en & h_wrap & v_wrap;
    end

    assign hs = ~((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign vs = ~((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: reads a grayscale framebuffer and drives a 640x480 VGA DAC.
// Optional macro VGA_BORDER_EN draws a white one-pixel frame around the image.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_data,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int     AW       = $clog2(IMG_W);
    localparam h_cnt_t IMG_W_C  = h_cnt_t'(IMG_W);
    localparam v_cnt_t IMG_H_C  = v_cnt_t'(IMG_H);

    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        raw_hs;
    logic        raw_vs;
    logic        raw_active;
    logic [15:0] addr_next;
    logic        in_img;
    logic        border;

    logic        s1_hs;
    logic        s1_vs;
    logic        s1_active;
    logic        s1_border;
    logic [7:0]  pixel;

    vga_timing u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs          (raw_hs),
        .vs          (raw_vs),
        .active      (raw_active),
        .frame_start (frame_start)
    );

    // row*IMG_W + col, with IMG_W a power of two
    assign addr_next = 16'((32'(v_cnt) << AW) | (32'(h_cnt) & 32'(IMG_W - 1)));
    assign in_img    = (h_cnt < IMG_W_C) && (v_cnt < IMG_H_C);

`ifdef VGA_BORDER_EN
    assign border = raw_active &&
                    (((h_cnt == IMG_W_C) && (v_cnt <= IMG_H_C)) ||
                     ((v_cnt == IMG_H_C) && (h_cnt <= IMG_W_C)));
`else
    assign border = 1'b0;
`endif

    // stage 1: issue the RAM read and carry the raw control flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_active <= 1'b0;
            s1_border <= 1'b0;
        end else if (pix_en) begin
            mem_addr  <= addr_next;
            mem_rd_en <= in_img;
            s1_hs     <= raw_hs;
            s1_vs     <= raw_vs;
            s1_active <= raw_active;
            s1_border <= border;
        end
    end

    // stage 2: pick RAM data, border white or black; align syncs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            pixel       <= 8'h00;
        end else if (pix_en) begin
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_blank_n <= s1_active;
            if (!s1_active)     pixel <= 8'h00;
            else if (mem_rd_en) pixel <= mem_data;
            else if (s1_border) pixel <= 8'hFF;
            else                pixel <= 8'h00;
        end
    end

    assign vga_clk    = pix_en;
    assign vga_sync_n = 1'b0;
    assign vga_r      = pixel;
    assign vga_g      = pixel;
    assign vga_b      = pixel;

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter IMG_W, default 256, meaning displayed image width in pixels (power of two).
REQ-002 Parameter IMG_H, default 256, meaning displayed image height in lines.
REQ-003 clk  input  1  system clock, 50 MHz, single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  output  16  framebuffer read address, row*IMG_W + col.
REQ-006 mem_rd_en  output  1  high when mem_addr is valid inside the image region.
REQ-007 mem_data  input  8  grayscale pixel from processor framebuffer port; synchronous RAM, 1-clk read latency.
REQ-008 vga_clk  output  1  25 MHz pixel clock, clk/2.
REQ-009 vga_hs, vga_vs  output  1 each  sync pulses, active low.
REQ-010 vga_blank_n  output  1  high during active 640x480 area.
REQ-011 vga_sync_n  output  1  tied 0.
REQ-012 vga_r, vga_g, vga_b  output  8 each  pixel colour.
REQ-013 frame_start  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-014 Internal pix_en SHALL toggle every clk; counters and pipeline advance only on cycles where pix_en=1.
REQ-015 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment on h wrap, count 0..524, and wrap to 0.
REQ-016 Timing: H active 0-639, front porch 640-655, sync 656-751, back porch 752-799; V active 0-479, fp 480-489, sync 490-491, bp 492-524.
REQ-017 Stage 1: mem_addr = {v_cnt[7:0], h_cnt[7:0]} (for defaults); mem_rd_en = (h_cnt<IMG_W && v_cnt<IMG_H).
REQ-018 Stage 2: vga_r/g/b = mem_data if the stage-1 mem_rd_en was 1, else 0x00.
REQ-019 vga_hs, vga_vs, vga_blank_n SHALL be delayed through the same two pixel-tick pipeline, aligning them with RGB.
REQ-020 Total latency from counter position to pixel output SHALL be exactly 2 pixel ticks (4 clk).
REQ-021 RGB SHALL be 0x00 whenever vga_blank_n is 0.
REQ-022 The block has no stall input; mem_data is assumed valid one clk after mem_addr, and there is no backpressure.

Reset
REQ-023 While reset=1, the following SHALL hold: h_cnt=0, v_cnt=0, pix_en=0, vga_clk=0, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, mem_rd_en=0, mem_addr=0, frame_start=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); on release, counting SHALL restart at (0,0) and the pipeline SHALL refill with no stale pixel output.

Configuration
REQ-025 With macro VGA_BORDER_EN defined, a pixel with (h==IMG_W && v<=IMG_H) or (v==IMG_H && h<=IMG_W) SHALL output 0xFF on all channels; without the macro, these pixels SHALL output 0x00.

Structure
REQ-026 Package vga_pkg SHALL hold the H/V timing localparams (active, fp, sync, bp, totals) and the counter width typedefs.
REQ-027 A sub-module vga_timing SHALL generate h_cnt, v_cnt, raw sync, active and frame_start; vga_frame_reader SHALL add the memory interface and pipeline.

Verification
REQ-028 The bench SHALL hold reset=1 for 3 clk and check every output against the values in REQ-023.
REQ-029 After reset release, the bench SHALL measure vga_hs: low for 192 clk, period 1600 clk; and vga_vs: low for 3200 clk, period 840000 clk.
REQ-030 The bench SHALL drive a RAM model returning 0xAB at address 0x0000, then check vga_r/g/b=0xAB on the first active pixel, 4 clk after the counters reach (0,0).
REQ-031 At h_cnt=300, v_cnt=10, the bench SHALL check mem_rd_en=0 and RGB=0x00; at h_cnt=700, the bench SHALL check vga_blank_n=0 and RGB=0.
REQ-032 With VGA_BORDER_EN defined, the bench SHALL check that pixel (256,100) and pixel (100,256) are 0xFFFFFF; without the macro, both SHALL be 0x000000.
REQ-033 The bench SHALL assert reset at v_cnt=200 for 2 clk, then check that the counters restart at (0,0), frame_start pulses once, and hs/vs timing matches REQ-029.
